nibble_stream_master: RTL and testbench

NIBBLE_STREAM_MASTER -- requirements
Module: nibble_stream_master

---
 rtl/nibble_stream_master.sv | 176 +++++++++++++++++
 tb/tb_nibble_stream_master.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_stream_master.sv
// nibble_stream_master
//
// Feeds two OW-bit operands, one 4-bit digit per cycle and LSB first, to an
// external digit-serial adder. It collects the returned sum digits and the
// final carry, then presents the assembled OW+1-bit sum on a valid/ready
// response port.
//
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   req_valid/req_ready   operand-pair handshake; req_a, req_b are the operands
//   dig_valid             frame valid towards the adder (its in_valid)
//   dig_x, dig_y          current operand digits, forced to 0 when dig_valid=0
//   dig_s, dig_c          sum digit and carry from the adder, one cycle after
//                         the digits that produced them
//   rsp_valid/rsp_ready   response handshake; rsp_sum = {carry, sum digits}
//
// Frame timing for N_DIG=4, with the request accepted at edge E0:
//   cycles 1..4 SEND (digits 0..3), cycle 5 DRAIN, cycle 6 RESP.
// DRAIN and RESP together keep dig_valid low for at least two cycles between
// frames, so the adder restarts its digit count and its carry at zero.

module nibble_stream_master #(
    parameter int unsigned N_DIG = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [4*N_DIG-1:0]   req_a,
    input  logic [4*N_DIG-1:0]   req_b,

    output logic                 dig_valid,
    output logic [3:0]           dig_x,
    output logic [3:0]           dig_y,
    input  logic [3:0]           dig_s,
    input  logic                 dig_c,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [4*N_DIG:0]     rsp_sum
);

    localparam int unsigned OW   = 4 * N_DIG;
    localparam int unsigned SW   = OW + 1;
    localparam int unsigned IdxW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    localparam logic [IdxW-1:0] IdxLast = IdxW'(N_DIG - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StDrain,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic [OW-1:0]     a_q, a_d;
    logic [OW-1:0]     b_q, b_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [SW-1:0]     sum_q, sum_d;

    // Digit slot of sum_q that takes dig_s at the coming edge.
    logic              cap_en;
    logic [IdxW-1:0]   cap_idx;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        cap_en    = 1'b0;
        cap_idx   = '0;
        req_ready = 1'b0;
        dig_valid = 1'b0;
        rsp_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = StSend;
                end
            end

            StSend: begin
                dig_valid = 1'b1;
                // The adder answers one cycle late: while digit i is being
                // driven, dig_s carries the result of digit i-1.
                if (idx_q != '0) begin
                    cap_en  = 1'b1;
                    cap_idx = idx_q - IdxW'(1);
                end
                // The index stops at the last digit instead of wrapping; the
                // next accepted word reloads it with zero.
                if (idx_q == IdxLast) begin
                    state_d = StDrain;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end

            StDrain: begin
                // Last digit's result and the word's final carry arrive now.
                cap_en    = 1'b1;
                cap_idx   = IdxLast;
                sum_d[OW] = dig_c;
                state_d   = StResp;
            end

            StResp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Digit capture, with constant slice positions.
        for (int unsigned d = 0; d < N_DIG; d++) begin
            if (cap_en && (cap_idx == IdxW'(d))) begin
                sum_d[4*d +: 4] = dig_s;
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit mux towards the adder; idle digits are forced to zero.
    // ------------------------------------------------------------------
    always_comb begin
        dig_x = '0;
        dig_y = '0;
        if (dig_valid) begin
            for (int unsigned d = 0; d < N_DIG; d++) begin
                if (idx_q == IdxW'(d)) begin
                    dig_x = a_q[4*d +: 4];
                    dig_y = b_q[4*d +: 4];
                end
            end
        end
    end

    assign rsp_sum = sum_q;

endmodule

// File: tb/tb_nibble_stream_master.sv
// Self-checking bench for nibble_stream_master with N_DIG=4 and a behavioural
// digit-serial adder that has one cycle of latency. It uses a table of
// directed operand pairs, seeded random operand pairs whose expected sum is
// plain A+B, and hand-written sequences for back-pressure, back-to-back
// requests and a reset during a frame.

module tb_nibble_stream_master;

    localparam int unsigned N_DIG = 4;
    localparam int unsigned OW    = 4 * N_DIG;
    localparam int unsigned SW    = OW + 1;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [OW-1:0] req_a;
    logic [OW-1:0] req_b;
    logic          dig_valid;
    logic [3:0]    dig_x;
    logic [3:0]    dig_y;
    logic [3:0]    dig_s;
    logic          dig_c;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [SW-1:0] rsp_sum;

    int unsigned checks;
    int unsigned failures;

    nibble_stream_master #(
        .N_DIG (N_DIG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .dig_valid (dig_valid),
        .dig_x     (dig_x),
        .dig_y     (dig_y),
        .dig_s     (dig_s),
        .dig_c     (dig_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Digit-serial adder: a one-cycle registered digit add. The carry chains
    // across consecutive valid digits and clears in any idle cycle.
    logic [3:0] add_s_q;
    logic       add_c_q;
    logic       add_cin_q;
    logic [4:0] add_tmp;

    always_comb add_tmp = {1'b0, dig_x} + {1'b0, dig_y} + {4'b0, add_cin_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_s_q   <= '0;
            add_c_q   <= 1'b0;
            add_cin_q <= 1'b0;
        end else if (dig_valid) begin
            add_s_q   <= add_tmp[3:0];
            add_c_q   <= add_tmp[4];
            add_cin_q <= add_tmp[4];
        end else begin
            add_cin_q <= 1'b0;
        end
    end

    assign dig_s = add_s_q;
    assign dig_c = add_c_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One complete word, cycle-exact. It enters just after a negedge with
    // the DUT idle and returns at a negedge with the DUT idle again.
    task automatic do_word(input logic [OW-1:0] a, input logic [OW-1:0] b,
                           input logic [SW-1:0] exp, input int unsigned stall,
                           input string tag);
        logic [OW-1:0] sa;
        logic [OW-1:0] sb;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        rsp_ready = (stall == 0);
        check({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < int'(N_DIG); i++) begin
            sa = a >> (4 * i);
            sb = b >> (4 * i);
            check($sformatf("%s dig_valid d%0d", tag, i), 32'(dig_valid), 32'd1);
            check($sformatf("%s dig_x d%0d", tag, i), 32'(dig_x), 32'(sa[3:0]));
            check($sformatf("%s dig_y d%0d", tag, i), 32'(dig_y), 32'(sb[3:0]));
            check($sformatf("%s req_ready send d%0d", tag, i), 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        // Drain cycle
        check({tag, " drain dig_valid"}, 32'(dig_valid), 32'd0);
        check({tag, " drain dig_x"}, 32'(dig_x), 32'd0);
        check({tag, " drain rsp_valid"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        // Cycle N_DIG+2 after acceptance
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, " rsp_sum"}, 32'(rsp_sum), 32'(exp));
        for (int k = 0; k < int'(stall); k++) begin
            check($sformatf("%s stall%0d rsp_valid", tag, k), 32'(rsp_valid), 32'd1);
            check($sformatf("%s stall%0d rsp_sum", tag, k), 32'(rsp_sum), 32'(exp));
            check($sformatf("%s stall%0d req_ready", tag, k), 32'(req_ready), 32'd0);
            check($sformatf("%s stall%0d dig_valid", tag, k), 32'(dig_valid), 32'd0);
            // A stray request offered while the response is stalled.
            if (k == 1) begin
                req_valid = 1'b1;
                req_a     = OW'($urandom);
                req_b     = OW'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        check({tag, " rsp_valid at handshake"}, 32'(rsp_valid), 32'd1);
        check({tag, " rsp_sum at handshake"}, 32'(rsp_sum), 32'(exp));
        @(negedge clk);
        check({tag, " back to idle req_ready"}, 32'(req_ready), 32'd1);
        check({tag, " back to idle rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, " back to idle dig_valid"}, 32'(dig_valid), 32'd0);
    endtask

    typedef struct {
        logic [OW-1:0] a;
        logic [OW-1:0] b;
        logic [SW-1:0] sum;
        int unsigned   stall;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [OW-1:0] ra;
        logic [OW-1:0] rb;
        logic [SW-1:0] rexp;
        logic [SW-1:0] exp_q[$];
        logic [SW-1:0] got;
        int            gap;
        int            gaps;
        int            min_gap;
        int            resps;
        int            bad;
        bit            seen;

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        vecs[0] = '{a: 16'h1234, b: 16'h4321, sum: 17'h05555, stall: 0};
        vecs[1] = '{a: 16'hFFFF, b: 16'h0001, sum: 17'h10000, stall: 0};
        vecs[2] = '{a: 16'hFFFF, b: 16'hFFFF, sum: 17'h1FFFE, stall: 0};
        vecs[3] = '{a: 16'h0000, b: 16'h0000, sum: 17'h00000, stall: 0};
        vecs[4] = '{a: 16'h9999, b: 16'h6667, sum: 17'h10000, stall: 1};
        vecs[5] = '{a: 16'hABCD, b: 16'h1111, sum: 17'h0BCDE, stall: 5};
        vecs[6] = '{a: 16'h8000, b: 16'h8000, sum: 17'h10000, stall: 0};
        vecs[7] = '{a: 16'h0F0F, b: 16'h00F1, sum: 17'h01000, stall: 2};

        // Reset held for 3 cycles
        repeat (3) @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset dig_valid", 32'(dig_valid), 32'd0);
        check("reset dig_x", 32'(dig_x), 32'd0);
        check("reset dig_y", 32'(dig_y), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_sum", 32'(rsp_sum), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            do_word(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].stall,
                    $sformatf("vec%0d", i));
        end

        // Random operands against plain arithmetic
        for (int i = 0; i < 16; i++) begin
            ra   = OW'($urandom);
            rb   = OW'($urandom);
            rexp = {1'b0, ra} + {1'b0, rb};
            do_word(ra, rb, rexp, $urandom_range(0, 2), $sformatf("rnd%0d", i));
        end

        // Back-to-back: req_valid held high, rsp_ready high
        exp_q.push_back(17'h05555);
        exp_q.push_back(17'h1FFFE);
        req_a     = 16'h1234;
        req_b     = 16'h4321;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        gap = 0; gaps = 0; min_gap = 1000; resps = 0; seen = 1'b0;
        for (int cyc = 0; cyc < 40 && resps < 2; cyc++) begin
            @(negedge clk);
            if (dig_valid) begin
                if (seen && gap > 0) begin
                    gaps++;
                    if (gap < min_gap) min_gap = gap;
                end
                if (!seen) begin
                    req_a = 16'hFFFF;
                    req_b = 16'hFFFF;
                end
                seen = 1'b1;
                gap  = 0;
            end else if (seen) begin
                gap++;
            end
            if (rsp_valid) begin
                got = exp_q.pop_front();
                check($sformatf("b2b rsp_sum %0d", resps), 32'(rsp_sum), 32'(got));
                resps++;
                if (resps == 2) req_valid = 1'b0;
            end
        end
        check("b2b responses", 32'(resps), 32'd2);
        check("b2b frame gaps", 32'(gaps), 32'd1);
        check("b2b min gap >= 2", 32'(min_gap >= 2), 32'd1);
        @(negedge clk);
        check("b2b idle after", 32'(req_ready), 32'd1);

        // Reset while digit 2 is being driven
        req_valid = 1'b1;
        req_a     = 16'h1234;
        req_b     = 16'h4321;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort dig_valid before reset", 32'(dig_valid), 32'd1);
        check("abort dig_x before reset", 32'(dig_x), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        check("abort async dig_valid", 32'(dig_valid), 32'd0);
        check("abort async dig_x", 32'(dig_x), 32'd0);
        check("abort async dig_y", 32'(dig_y), 32'd0);
        check("abort async req_ready", 32'(req_ready), 32'd1);
        check("abort async rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort async rsp_sum", 32'(rsp_sum), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid || dig_valid) bad++;
        end
        check("abort no response", 32'(bad), 32'd0);
        do_word(16'h0F0F, 16'h00F1, 17'h01000, 0, "post-reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
